// File: rtl/wb_stage_nlane_pkg.sv
// wb_stage_nlane_pkg: shared widths, trace entry layout and trace FIFO states
package wb_stage_nlane_pkg;
  localparam int STALL_W = 6;
  localparam int TRACE_ENTRY_W = 70;
  typedef struct packed {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } trace_entry_t;
  typedef enum logic [1:0] {ST_EMPTY, ST_ACTIVE, ST_THROTTLE} trace_state_t;
  function automatic int wb_lane_w(input int hilo_w);
    return hilo_w + TRACE_ENTRY_W;
  endfunction
  function automatic int wb_rf_lane_w(input int hilo_w);
    return hilo_w + 38;
  endfunction
endpackage

// File: rtl/wb_stage_nlane_trace_fifo.sv
// wb_stage_nlane_trace_fifo: multi-push, single-pop trace FIFO with compaction, throttle and sticky overflow
module wb_stage_nlane_trace_fifo
  import wb_stage_nlane_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES-1:0]        push_valid,
  input  trace_entry_t [LANES-1:0] push_data,
  output logic                    pop_valid,
  output trace_entry_t            pop_data,
  output logic                    stallreq,
  output logic                    overflow
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int THR = DEPTH - 2 * LANES;
  trace_entry_t mem_q [DEPTH];
  trace_entry_t mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic overflow_q, overflow_d;
  trace_state_t state_q, state_d;
  int free, n_acc;
  assign pop_valid = count_q != '0;
  assign pop_data = mem_q[rptr_q];
  assign stallreq = state_q == ST_THROTTLE;
  assign overflow = overflow_q;
  // Accepted lanes form a prefix of the traceable lanes, so n_acc doubles as the compacted slot index.
  always_comb begin
    mem_d = mem_q;
    n_acc = 0;
    free = DEPTH - int'(count_q) + int'(pop_valid);
    overflow_d = overflow_q;
    for (int i = 0; i < LANES; i++)
      if (push_valid[i]) begin
        if (n_acc < free) begin
          mem_d[PTR_W'(int'(wptr_q) + n_acc)] = push_data[i];
          n_acc = n_acc + 1;
        end else overflow_d = 1'b1;
      end
    wptr_d = wptr_q + PTR_W'(n_acc);
    rptr_d = rptr_q + PTR_W'(pop_valid);
    count_d = CNT_W'(int'(count_q) + n_acc - int'(pop_valid));
    state_d = count_d == '0 ? ST_EMPTY : int'(count_d) > THR ? ST_THROTTLE : ST_ACTIVE;
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
      overflow_q <= 1'b0;
      state_q <= ST_EMPTY;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
      overflow_q <= overflow_d;
      state_q <= state_d;
    end
  end
endmodule

// File: rtl/wb_stage_nlane.sv
// wb_stage_nlane: N-lane write-back stage with register-file lanes and serialised debug trace
module wb_stage_nlane
  import wb_stage_nlane_pkg::*;
#(
  parameter int LANES       = 2,
  parameter int HILO_W      = 66,
  parameter int TRACE_DEPTH = 8,
  parameter int STALL_IDX   = 4,
  parameter bit FLUSH_EN    = 1'b0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic [STALL_W-1:0]                    stall,
  input  logic [LANES*wb_lane_w(HILO_W)-1:0]    mem_to_wb_bus,
  output logic [LANES*wb_rf_lane_w(HILO_W)-1:0] wb_to_rf_bus,
  output logic                                  trace_stallreq,
  output logic                                  trace_overflow,
  output logic [31:0]                           debug_wb_pc,
  output logic [3:0]                            debug_wb_rf_wen,
  output logic [4:0]                            debug_wb_rf_wnum,
  output logic [31:0]                           debug_wb_rf_wdata
);
  localparam int LANE_W = wb_lane_w(HILO_W);
  localparam int RF_LANE_W = wb_rf_lane_w(HILO_W);
  logic [LANES*LANE_W-1:0] bus_q, bus_d;
  logic fresh_q, fresh_d;
  logic [LANES-1:0] push_valid;
  trace_entry_t [LANES-1:0] push_data;
  logic pop_valid;
  trace_entry_t pop_data, dbg_q, dbg_d;
  logic [3:0] dbg_wen_q, dbg_wen_d;
  logic flush_hit, unused_stall;
  assign unused_stall = ^stall;
  assign flush_hit = FLUSH_EN && flush;
  // A stalled stage whose successor moves on must emit a bubble; otherwise a stall holds.
  always_comb begin
    bus_d = flush_hit ? '0 : !stall[STALL_IDX] ? mem_to_wb_bus : !stall[STALL_IDX+1] ? '0 : bus_q;
    fresh_d = !flush_hit && !stall[STALL_IDX];
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign push_data[i] = bus_q[i*LANE_W +: TRACE_ENTRY_W];
    assign push_valid[i] = fresh_q && push_data[i].pc != '0;
    assign wb_to_rf_bus[i*RF_LANE_W +: RF_LANE_W] =
      {bus_q[i*LANE_W+TRACE_ENTRY_W +: HILO_W], bus_q[i*LANE_W +: 38]};
  end
  wb_stage_nlane_trace_fifo #(.LANES(LANES), .DEPTH(TRACE_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_valid(push_valid),
    .push_data (push_data),
    .pop_valid (pop_valid),
    .pop_data  (pop_data),
    .stallreq  (trace_stallreq),
    .overflow  (trace_overflow)
  );
  always_comb begin
    dbg_d = pop_valid ? pop_data : dbg_q;
    dbg_wen_d = pop_valid ? {4{pop_data.we}} : 4'h0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_q <= '0;
      fresh_q <= 1'b0;
      dbg_q <= '0;
      dbg_wen_q <= 4'h0;
    end else begin
      bus_q <= bus_d;
      fresh_q <= fresh_d;
      dbg_q <= dbg_d;
      dbg_wen_q <= dbg_wen_d;
    end
  end
  assign debug_wb_pc = dbg_q.pc;
  assign debug_wb_rf_wen = dbg_wen_q;
  assign debug_wb_rf_wnum = dbg_q.waddr;
  assign debug_wb_rf_wdata = dbg_q.wdata;
endmodule

// File: tb/tb_wb_stage_nlane.sv
// tb_wb_stage_nlane: scoreboard bench for the two-lane write-back stage and its debug trace
module tb_wb_stage_nlane;
  localparam int LW = 136;
  localparam int RW = 104;
  localparam logic [5:0] HOLD = 6'b110000;
  localparam logic [5:0] BUBBLE = 6'b010000;
  logic clk = 1'b0;
  logic rst, flush;
  logic [5:0] stall;
  logic [2*LW-1:0] mem_to_wb_bus;
  logic [2*RW-1:0] wb_to_rf_bus;
  logic trace_stallreq, trace_overflow;
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0] debug_wb_rf_wen;
  logic [4:0] debug_wb_rf_wnum;
  typedef struct {logic [31:0] pc; logic [4:0] n; logic [31:0] d;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  int n_tests = 0;
  int n_fail = 0;

  wb_stage_nlane #(.LANES(2), .HILO_W(66), .TRACE_DEPTH(8), .STALL_IDX(4), .FLUSH_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall), .mem_to_wb_bus(mem_to_wb_bus),
    .wb_to_rf_bus(wb_to_rf_bus), .trace_stallreq(trace_stallreq), .trace_overflow(trace_overflow),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] mk_lane(input logic [31:0] pc, input logic we, input logic [4:0] n, input logic [31:0] d);
    return {2'b11, d, pc, pc, we, n, d};
  endfunction
  function automatic logic [RW-1:0] mk_rf(input logic [31:0] pc, input logic we, input logic [4:0] n, input logic [31:0] d);
    return {2'b11, d, pc, we, n, d};
  endfunction
  function automatic logic [31:0] lpc(input int b, input int i);
    return 32'hBFC01000 + 32'(b * 8 + i * 4);
  endfunction
  function automatic logic [4:0] ln(input int b, input int i);
    return 5'((b * 2 + i) % 31 + 1);
  endfunction
  function automatic logic [31:0] ld(input int b, input int i);
    return 32'hA000 + 32'(b * 2 + i);
  endfunction
  function automatic logic [2*LW-1:0] bundle(input int b);
    return {mk_lane(lpc(b, 1), 1'b1, ln(b, 1), ld(b, 1)), mk_lane(lpc(b, 0), 1'b1, ln(b, 0), ld(b, 0))};
  endfunction
  function automatic logic [2*RW-1:0] bundle_rf(input int b);
    return {mk_rf(lpc(b, 1), 1'b1, ln(b, 1), ld(b, 1)), mk_rf(lpc(b, 0), 1'b1, ln(b, 0), ld(b, 0))};
  endfunction

  task automatic push_exp(input logic [31:0] pc, input logic [4:0] n, input logic [31:0] d);
    exp_t x;
    x.pc = pc;
    x.n = n;
    x.d = d;
    exp_q.push_back(x);
  endtask
  task automatic push_bundle(input int b, input bit l1);
    push_exp(lpc(b, 0), ln(b, 0), ld(b, 0));
    if (l1) push_exp(lpc(b, 1), ln(b, 1), ld(b, 1));
  endtask
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask
  task automatic drain(input string nm);
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) cycle();
    repeat (4) cycle();
    chk(nm, 256'(exp_q.size()), 256'(0));
  endtask

  always @(negedge clk)
    if (!rst && debug_wb_rf_wen != 4'h0) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_trace actual pc=%0h required none", debug_wb_pc);
      end else begin
        e = exp_q.pop_front();
        chk("trace_pc", 256'(debug_wb_pc), 256'(e.pc));
        chk("trace_wen", 256'(debug_wb_rf_wen), 256'(4'hF));
        chk("trace_wnum", 256'(debug_wb_rf_wnum), 256'(e.n));
        chk("trace_wdata", 256'(debug_wb_rf_wdata), 256'(e.d));
      end
    end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int sent, first;
    rst = 1'b1;
    flush = 1'b0;
    stall = HOLD;
    mem_to_wb_bus = '0;
    cycle();
    cycle();
    chk("rst_rf_bus", 256'(wb_to_rf_bus), 256'(0));
    chk("rst_pc", 256'(debug_wb_pc), 256'(0));
    chk("rst_wen", 256'(debug_wb_rf_wen), 256'(0));
    chk("rst_stallreq", 256'(trace_stallreq), 256'(0));
    chk("rst_overflow", 256'(trace_overflow), 256'(0));
    rst = 1'b0;
    cycle();
    // basic two-lane capture and latency
    mem_to_wb_bus = {mk_lane(32'hBFC00004, 1'b1, 5'd4, 32'h22), mk_lane(32'hBFC00000, 1'b1, 5'd3, 32'h11)};
    push_exp(32'hBFC00000, 5'd3, 32'h11);
    push_exp(32'hBFC00004, 5'd4, 32'h22);
    stall = 6'b0;
    cycle();
    stall = HOLD;
    chk("t1_rf_bus", 256'(wb_to_rf_bus),
        256'({mk_rf(32'hBFC00004, 1'b1, 5'd4, 32'h22), mk_rf(32'hBFC00000, 1'b1, 5'd3, 32'h11)}));
    chk("t1_wen_e0", 256'(debug_wb_rf_wen), 256'(0));
    cycle();
    chk("t1_wen_e1", 256'(debug_wb_rf_wen), 256'(0));
    cycle();
    chk("t1_pc_e2", 256'(debug_wb_pc), 256'(32'hBFC00000));
    cycle();
    chk("t1_pc_e3", 256'(debug_wb_pc), 256'(32'hBFC00004));
    cycle();
    chk("t1_wen_e4", 256'(debug_wb_rf_wen), 256'(0));
    chk("t1_pc_hold", 256'(debug_wb_pc), 256'(32'hBFC00004));
    drain("t1_drain");
    // held bundle is traced once
    mem_to_wb_bus = bundle(1);
    push_bundle(1, 1'b1);
    stall = 6'b0;
    cycle();
    stall = HOLD;
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_bus", 256'(wb_to_rf_bus), 256'(bundle_rf(1)));
      cycle();
    end
    drain("t2_drain");
    // bubble when the successor is not stalled
    stall = BUBBLE;
    cycle();
    chk("t3_bubble", 256'(wb_to_rf_bus), 256'(0));
    stall = HOLD;
    cycle();
    chk("t3_bubble_hold", 256'(wb_to_rf_bus), 256'(0));
    drain("t3_drain");
    // pc=0 lane is skipped and the next lane compacts into the head slot
    mem_to_wb_bus = {mk_lane(32'hBFC00100, 1'b1, 5'd7, 32'h77), mk_lane(32'h0, 1'b1, 5'd6, 32'h66)};
    push_exp(32'hBFC00100, 5'd7, 32'h77);
    stall = 6'b0;
    cycle();
    stall = HOLD;
    cycle();
    cycle();
    chk("tc_pc_e2", 256'(debug_wb_pc), 256'(32'hBFC00100));
    drain("tc_drain");
    // back-to-back bundles honouring trace_stallreq
    sent = 0;
    first = -1;
    for (int c = 0; c < 200 && sent < 8; c++) begin
      if (trace_stallreq) begin
        if (first < 0) first = sent;
        stall = HOLD;
      end else begin
        mem_to_wb_bus = bundle(10 + sent);
        push_bundle(10 + sent, 1'b1);
        stall = 6'b0;
        sent++;
      end
      cycle();
    end
    stall = HOLD;
    chk("t4_sent", 256'(sent), 256'(8));
    chk("t4_first_stallreq", 256'(first), 256'(5));
    drain("t4_drain");
    chk("t4_overflow", 256'(trace_overflow), 256'(0));
    chk("t4_stallreq_idle", 256'(trace_stallreq), 256'(0));
    // same traffic ignoring stallreq: only the youngest lane of the last bundle is lost
    for (int b = 0; b < 8; b++) begin
      mem_to_wb_bus = bundle(20 + b);
      push_bundle(20 + b, b != 7);
      stall = 6'b0;
      cycle();
    end
    stall = HOLD;
    chk("t5_ovf_before", 256'(trace_overflow), 256'(0));
    cycle();
    chk("t5_ovf_set", 256'(trace_overflow), 256'(1));
    drain("t5_drain");
    chk("t5_ovf_sticky", 256'(trace_overflow), 256'(1));
    // reset with four entries queued
    for (int b = 0; b < 3; b++) begin
      mem_to_wb_bus = bundle(30 + b);
      if (b == 0) push_bundle(30, 1'b1);
      stall = 6'b0;
      cycle();
    end
    stall = HOLD;
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    cycle();
    chk("t6_pc", 256'(debug_wb_pc), 256'(0));
    chk("t6_wen", 256'(debug_wb_rf_wen), 256'(0));
    chk("t6_wnum", 256'(debug_wb_rf_wnum), 256'(0));
    chk("t6_wdata", 256'(debug_wb_rf_wdata), 256'(0));
    chk("t6_stallreq", 256'(trace_stallreq), 256'(0));
    chk("t6_overflow", 256'(trace_overflow), 256'(0));
    chk("t6_rf_bus", 256'(wb_to_rf_bus), 256'(0));
    rst = 1'b0;
    drain("t6_drain");
    // flush beats a simultaneous capture
    mem_to_wb_bus = bundle(40);
    push_bundle(40, 1'b1);
    stall = 6'b0;
    cycle();
    chk("tf_capture", 256'(wb_to_rf_bus), 256'(bundle_rf(40)));
    mem_to_wb_bus = bundle(41);
    flush = 1'b1;
    cycle();
    chk("tf_flush", 256'(wb_to_rf_bus), 256'(0));
    flush = 1'b0;
    stall = HOLD;
    cycle();
    chk("tf_flush_hold", 256'(wb_to_rf_bus), 256'(0));
    drain("tf_drain");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
